// File: rtl/fme_window_loader.sv
// Assembles two 8-pixel beats into a 16-sample window row and queues it in a
// 2-entry FIFO for the interpolation stage, with row stamping and framing checks.
module fme_window_loader #(
  parameter int DATAWIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic [8*DATAWIDTH-1:0]      in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATAWIDTH+7:0] A0,
  output logic signed [DATAWIDTH+7:0] A1,
  output logic signed [DATAWIDTH+7:0] A2,
  output logic signed [DATAWIDTH+7:0] A3,
  output logic signed [DATAWIDTH+7:0] A4,
  output logic signed [DATAWIDTH+7:0] A5,
  output logic signed [DATAWIDTH+7:0] A6,
  output logic signed [DATAWIDTH+7:0] A7,
  output logic signed [DATAWIDTH+7:0] A8,
  output logic signed [DATAWIDTH+7:0] A9,
  output logic signed [DATAWIDTH+7:0] A10,
  output logic signed [DATAWIDTH+7:0] A11,
  output logic signed [DATAWIDTH+7:0] A12,
  output logic signed [DATAWIDTH+7:0] A13,
  output logic signed [DATAWIDTH+7:0] A14,
  output logic signed [DATAWIDTH+7:0] A15,
  output logic [3:0]                  out_row,
  output logic                        out_last,
  output logic                        err
);

  localparam int HW = 8 * DATAWIDTH;
  localparam int SW = DATAWIDTH + 8;

  function automatic logic signed [SW-1:0] widen(input logic [DATAWIDTH-1:0] pix);
    return $signed({8'd0, pix});
  endfunction

  logic            half_vld_p0;
  logic [HW-1:0]   half_p0;
  logic [2*HW-1:0] win_p1 [2];
  logic [3:0]      row_p1 [2];
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [3:0]      row_cnt;
  logic            accept;
  logic            push;
  logic            pop;
  logic            frame_err;
  logic [2*HW-1:0] head;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = !half_vld_p0 || (count != 2'd2) || pop;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !in_first && half_vld_p0;
  // first-while-holding and second-without-half are both framing errors
  assign frame_err = accept && (in_first == half_vld_p0);

  // Stage p0: half-row capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_vld_p0 <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= frame_err;
      if (accept) half_vld_p0 <= in_first;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_first) half_p0 <= in_data;
  end

  // Stage p1: window FIFO and row stamping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        win_p1[i] <= '0;
        row_p1[i] <= '0;
      end
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_cnt <= 4'd0;
    end else begin
      if (push) begin
        win_p1[wr_ptr] <= {in_data, half_p0};
        row_p1[wr_ptr] <= row_cnt;
        wr_ptr         <= ~wr_ptr;
        row_cnt        <= row_cnt + 4'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head     = win_p1[rd_ptr];
  assign out_row  = row_p1[rd_ptr];
  assign out_last = (out_row == 4'd15);

  assign A0  = widen(head[ 0*DATAWIDTH +: DATAWIDTH]);
  assign A1  = widen(head[ 1*DATAWIDTH +: DATAWIDTH]);
  assign A2  = widen(head[ 2*DATAWIDTH +: DATAWIDTH]);
  assign A3  = widen(head[ 3*DATAWIDTH +: DATAWIDTH]);
  assign A4  = widen(head[ 4*DATAWIDTH +: DATAWIDTH]);
  assign A5  = widen(head[ 5*DATAWIDTH +: DATAWIDTH]);
  assign A6  = widen(head[ 6*DATAWIDTH +: DATAWIDTH]);
  assign A7  = widen(head[ 7*DATAWIDTH +: DATAWIDTH]);
  assign A8  = widen(head[ 8*DATAWIDTH +: DATAWIDTH]);
  assign A9  = widen(head[ 9*DATAWIDTH +: DATAWIDTH]);
  assign A10 = widen(head[10*DATAWIDTH +: DATAWIDTH]);
  assign A11 = widen(head[11*DATAWIDTH +: DATAWIDTH]);
  assign A12 = widen(head[12*DATAWIDTH +: DATAWIDTH]);
  assign A13 = widen(head[13*DATAWIDTH +: DATAWIDTH]);
  assign A14 = widen(head[14*DATAWIDTH +: DATAWIDTH]);
  assign A15 = widen(head[15*DATAWIDTH +: DATAWIDTH]);

endmodule

// File: tb/tb_fme_window_loader.sv
// Bench for fme_window_loader: directed scenarios plus random beats, checked
// against a queue-based model of the row/window behaviour.
module tb_fme_window_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  wire         in_ready;
  wire         out_valid;
  wire         out_last;
  wire         err;
  wire  [3:0]  out_row;
  wire signed [15:0] a [16];

  int errors = 0;
  int checks = 0;

  fme_window_loader #(.DATAWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]),
    .A6(a[6]), .A7(a[7]), .A8(a[8]), .A9(a[9]), .A10(a[10]), .A11(a[11]),
    .A12(a[12]), .A13(a[13]), .A14(a[14]), .A15(a[15]),
    .out_row(out_row), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   row;
  } win_t;

  win_t        q[$];
  logic        m_hv = 1'b0;
  logic [63:0] m_half = '0;
  logic [3:0]  m_row = 4'd0;
  logic        m_err = 1'b0;
  bit          rnd = 1'b0;

  function automatic logic model_ready();
    return !m_hv || (q.size() < 2) || (q.size() != 0 && out_ready);
  endfunction

  task automatic model_step();
    logic acc;
    if (!rst_n) begin
      q.delete();
      m_hv  = 1'b0;
      m_row = 4'd0;
      m_err = 1'b0;
      return;
    end
    acc   = in_valid && model_ready();
    m_err = 1'b0;
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (acc) begin
      if (in_first) begin
        m_err  = m_hv;
        m_half = in_data;
        m_hv   = 1'b1;
      end else if (m_hv) begin
        q.push_back('{d: {in_data, m_half}, row: m_row});
        m_row = m_row + 4'd1;
        m_hv  = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    win_t h;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (q.size() != 0) begin
      h = q[0];
      for (int k = 0; k < 16; k++)
        chk($sformatf("A%0d", k), {16'd0, a[k]}, {24'd0, h.d[8*k +: 8]});
      chk("out_row", {28'd0, out_row}, {28'd0, h.row});
      chk("out_last", {31'd0, out_last}, {31'd0, h.row == 4'd15});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive_beat(input logic first, input logic [63:0] data);
    int n = 0;
    in_valid = 1'b1;
    in_first = first;
    in_data  = data;
    forever begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (model_ready() || n >= 50) break;
      cyc();
      n++;
    end
    chk("ready_timeout", {31'd0, n < 50}, 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [63:0] lo, input logic [63:0] hi);
    drive_beat(1'b1, lo);
    drive_beat(1'b0, hi);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] y;
    logic        f;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_out_row", {28'd0, out_row}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_A0", {16'd0, a[0]}, 32'd0);
    chk("rst_A15", {16'd0, a[15]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic row
    out_ready = 1'b1;
    send_row(64'h0706050403020100, 64'hFFFEFDFCFBFAF9F8);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_A0", {16'd0, a[0]}, 32'h0000);
    chk("basic_A7", {16'd0, a[7]}, 32'h0007);
    chk("basic_A8", {16'd0, a[8]}, 32'h00F8);
    chk("basic_A15", {16'd0, a[15]}, 32'h00FF);
    chk("basic_row", {28'd0, out_row}, 32'd0);
    cyc();

    // random beats with occasional framing errors and random back-pressure
    rnd = 1'b1;
    repeat (60) begin
      f = ($urandom_range(0, 7) == 0) ? m_hv : !m_hv;
      drive_beat(f, {$urandom, $urandom});
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();

    // back-pressure, stability and simultaneous push/pop
    do_reset();
    out_ready = 1'b0;
    send_row({$urandom, $urandom}, {$urandom, $urandom});
    send_row({$urandom, $urandom}, {$urandom, $urandom});
    drive_beat(1'b1, {$urandom, $urandom});
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_first = 1'b0;
    in_data  = {$urandom, $urandom};
    repeat (3) begin
      cyc();
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_row", {28'd0, out_row}, 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("bp_swap_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_swap_row", {28'd0, out_row}, 32'd1);
    cyc();
    chk("bp_row2", {28'd0, out_row}, 32'd2);
    cyc();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // block wrap over 17 rows
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_row({$urandom, $urandom}, {$urandom, $urandom});
      chk("wrap_row", {28'd0, out_row}, 32'(i % 16));
      chk("wrap_last", {31'd0, out_last}, {31'd0, i == 15});
    end
    repeat (2) cyc();

    // framing errors
    y = {$urandom, $urandom};
    drive_beat(1'b1, {$urandom, $urandom});
    drive_beat(1'b1, y);
    chk("frame_dup_err", {31'd0, err}, 32'd1);
    drive_beat(1'b0, {$urandom, $urandom});
    chk("frame_win_A0", {16'd0, a[0]}, {24'd0, y[7:0]});
    chk("frame_win_A7", {16'd0, a[7]}, {24'd0, y[63:56]});
    chk("frame_win_row", {28'd0, out_row}, 32'd1);
    cyc();
    drive_beat(1'b0, {$urandom, $urandom});
    chk("lone_err", {31'd0, err}, 32'd1);
    chk("lone_no_win", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("lone_no_win2", {31'd0, out_valid}, 32'd0);

    // reset with a half and two windows held
    out_ready = 1'b0;
    send_row({$urandom, $urandom}, {$urandom, $urandom});
    send_row({$urandom, $urandom}, {$urandom, $urandom});
    drive_beat(1'b1, {$urandom, $urandom});
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_A0", {16'd0, a[0]}, 32'd0);
    chk("midrst_A15", {16'd0, a[15]}, 32'd0);
    chk("midrst_row", {28'd0, out_row}, 32'd0);
    check_all();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_row({$urandom, $urandom}, {$urandom, $urandom});
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_row", {28'd0, out_row}, 32'd0);
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fme_window_loader.md
FME_WINDOW_LOADER -- requirements
Module: fme_window_loader

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 8, giving the pixel width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the loader can accept a beat.
REQ-006 The module SHALL have port in_first, input, 1 bit: the offered beat is the first half of a row.
REQ-007 The module SHALL have port in_data, input, 8*DATAWIDTH bits: eight unsigned pixels; pixel k is at bits [DATAWIDTH*(k+1)-1 : DATAWIDTH*k].
REQ-008 The module SHALL have port out_valid, output, 1 bit: a 16-sample window is presented.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the downstream interpolation stage consumes the window.
REQ-010 The module SHALL have ports A0..A15, output, signed DATAWIDTH+8 bits each: window samples in row order.
REQ-011 The module SHALL have port out_row, output, 4 bits: the row index of the presented window within a 16-row block.
REQ-012 The module SHALL have port out_last, output, 1 bit: the presented window is row 15 of its block.
REQ-013 The module SHALL have port err, output, 1 bit: a one-cycle pulse on a framing error.

Function
REQ-014 Beat acceptance: a beat SHALL be accepted in any cycle where in_valid and in_ready are both 1; no other handshake exists.
REQ-015 Row assembly: an accepted first beat (in_first=1) SHALL be held in a half-register, with pixel k mapped to A(k).
REQ-016 Row completion: the next accepted beat with in_first=0 SHALL complete the row, with pixel k mapped to A(8+k), and the row SHALL be pushed into the output FIFO.
REQ-017 Sample widening: each pixel SHALL be zero-extended to DATAWIDTH+8 bits, so every sample is non-negative.
REQ-018 Output FIFO: a 2-entry output FIFO SHALL hold completed windows; out_valid SHALL equal (FIFO count != 0), and A0..A15, out_row and out_last SHALL reflect the head entry.
REQ-019 Pop: a pop SHALL occur when out_valid and out_ready are both 1; simultaneous push and pop SHALL leave the count unchanged, with order preserved.
REQ-020 Back-pressure: in_ready SHALL equal (!half_valid || count<2 || (out_valid && out_ready)), so a second beat is never accepted without FIFO space.
REQ-021 Stability: while out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-022 Row counter: a 4-bit row counter SHALL be stamped into each window at push and then increment, wrapping 15->0.
REQ-023 out_last: out_last SHALL equal (out_row==15).
REQ-024 Latency: a row completed in cycle N SHALL appear on the outputs in cycle N+1 when the FIFO was empty.
REQ-025 Framing error, in_first=1 while half_valid=1: the stored half SHALL be discarded, the new beat SHALL become the first half, err SHALL pulse, and the row counter SHALL be unchanged.
REQ-026 Framing error, in_first=0 while half_valid=0: the beat SHALL be discarded, err SHALL pulse, and no state SHALL change.
REQ-027 Combinational paths: the module SHALL contain no arithmetic on samples and no combinational path from in_data to A0..A15.

Reset
REQ-028 While rst_n=0, regardless of clk, the module SHALL force half_valid=0, FIFO count=0, row counter=0, out_valid=0, err=0, A0..A15=0, out_row=0, out_last=0 and in_ready=1.
REQ-029 Reset mid-row or mid-stall SHALL discard all partial and buffered data; after rst_n rises the first window SHALL carry out_row=0.

Verification
REQ-030 Basic row (DATAWIDTH=8): beat1 with pixels 0x00..0x07 (first=1), then beat2 with pixels 0xF8..0xFF, out_ready=1 -> one cycle later out_valid=1, A0=0, A7=7, A8=248 (16'h00F8), A15=255, out_row=0.
REQ-031 Back-pressure: hold out_ready=0 and stream 3 rows -> two windows buffered, in_ready=0 after the 3rd first beat; release out_ready -> rows 0, 1, 2 are delivered in order with no loss.
REQ-032 Block wrap: 17 consecutive rows -> out_last=1 only on the 16th window (out_row=15); the 17th window has out_row=0.
REQ-033 Framing errors: first, first, second -> err pulses once, and the window contains the second first beat; a lone second beat -> err pulses and no window is produced.
REQ-034 Reset mid-operation: assert rst_n=0 with one half and two windows held -> outputs clear immediately; the next row gives out_row=0.
REQ-035 Simultaneous events: count=2 with pop and second-beat push in the same cycle -> count stays 2 and order is preserved.
